// File: rtl/vx_mem_rsp_gather.sv
// Gathers the partial read responses of one request into a single full response.
// Read requests are snooped to learn each tag's expected lane mask; partials are merged per slot.
module vx_mem_rsp_gather #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int UUID_WIDTH = 0,
  parameter int SLOT_BITS  = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  input  logic                           req_ready,
  input  logic                           req_rw,
  input  logic [NUM_REQS-1:0]            req_mask,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           req_stall,
  input  logic                           in_rsp_valid,
  input  logic [NUM_REQS-1:0]            in_rsp_mask,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_rsp_data,
  input  logic [TAG_WIDTH-1:0]           in_rsp_tag,
  output logic                           in_rsp_ready,
  output logic                           out_rsp_valid,
  output logic [NUM_REQS-1:0]            out_rsp_mask,
  output logic [NUM_REQS*DATA_WIDTH-1:0] out_rsp_data,
  output logic [TAG_WIDTH-1:0]           out_rsp_tag,
  input  logic                           out_rsp_ready
);
  localparam int NUM_SLOTS   = 2 ** SLOT_BITS;
  localparam int TAG_ID_BITS = TAG_WIDTH - UUID_WIDTH;
  localparam int DW          = NUM_REQS * DATA_WIDTH;

  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [NUM_REQS-1:0]  got_mask_q [NUM_SLOTS];
  logic [NUM_REQS-1:0]  got_mask_d [NUM_SLOTS];
  logic [NUM_REQS-1:0]  exp_mask_q [NUM_SLOTS];
  logic [NUM_REQS-1:0]  exp_mask_d [NUM_SLOTS];
  logic [TAG_WIDTH-1:0] tag_q      [NUM_SLOTS];
  logic [TAG_WIDTH-1:0] tag_d      [NUM_SLOTS];
  logic [DW-1:0]        data_q     [NUM_SLOTS];
  logic [DW-1:0]        data_d     [NUM_SLOTS];

  logic                 out_valid_q, out_valid_d;
  logic [NUM_REQS-1:0]  out_mask_q, out_mask_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

  logic [SLOT_BITS-1:0] rec_slot, in_slot;
  logic                 rec_fire, in_fire, in_apply, complete;
  logic [NUM_REQS-1:0]  eff, merged;
  logic [DW-1:0]        merged_data;

  assign rec_slot     = req_tag[SLOT_BITS-1:0];
  assign in_slot      = in_rsp_tag[SLOT_BITS-1:0];
  assign rec_fire     = req_valid & req_ready & ~req_rw;
  assign req_stall    = busy_q[rec_slot];
  assign in_rsp_ready = ~out_valid_q | out_rsp_ready;
  assign in_fire      = in_rsp_valid & in_rsp_ready;

  // A record landing on the same slot as a partial overrides it entirely.
  assign in_apply = in_fire & busy_q[in_slot] & ~(rec_fire & (rec_slot == in_slot));
  assign eff      = in_rsp_mask & exp_mask_q[in_slot];
  assign merged   = got_mask_q[in_slot] | eff;
  // An empty expected mask is a protocol error; such a slot must never complete.
  assign complete = in_apply & (merged == exp_mask_q[in_slot]) & (|exp_mask_q[in_slot]);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    merged_data = data_q[in_slot];
    for (int l = 0; l < NUM_REQS; l++) begin
      if (eff[l]) merged_data[l*DATA_WIDTH +: DATA_WIDTH] = in_rsp_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    busy_d     = busy_q;
    got_mask_d = got_mask_q;
    exp_mask_d = exp_mask_q;
    tag_d      = tag_q;
    data_d     = data_q;
    out_valid_d = out_valid_q & ~out_rsp_ready;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (in_apply) begin
      data_d[in_slot] = merged_data;
      if (complete) begin
        busy_d[in_slot]     = 1'b0;
        got_mask_d[in_slot] = '0;
        out_valid_d         = 1'b1;
        out_mask_d          = exp_mask_q[in_slot];
        out_data_d          = merged_data;
        out_tag_d           = tag_q[in_slot];
      end else begin
        got_mask_d[in_slot] = merged;
      end
    end

    if (rec_fire) begin
      busy_d[rec_slot]     = 1'b1;
      exp_mask_d[rec_slot] = req_mask;
      got_mask_d[rec_slot] = '0;
      tag_d[rec_slot]      = req_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= '0;
      got_mask_q  <= '{default: '0};
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      got_mask_q  <= got_mask_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // NOTE: slot payload is qualified by busy/got_mask, so this storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    exp_mask_q <= exp_mask_d;
    tag_q      <= tag_d;
    data_q     <= data_d;
  end

  assign out_rsp_valid = out_valid_q;
  assign out_rsp_mask  = out_mask_q;
  assign out_rsp_data  = out_data_q;
  assign out_rsp_tag   = out_tag_q;

  // Protocol checks on the snooped request and partial response streams.
  a_cfg_slot_bits: assert property (@(posedge clk) SLOT_BITS <= TAG_ID_BITS);
  a_rec_busy:      assert property (@(posedge clk) disable iff (!reset_n) rec_fire |-> !busy_q[rec_slot]);
  a_rec_empty:     assert property (@(posedge clk) disable iff (!reset_n) rec_fire |-> (|req_mask));
  a_rec_collide:   assert property (@(posedge clk) disable iff (!reset_n)
                                    (rec_fire && in_fire) |-> (rec_slot != in_slot));
  a_rsp_idle:      assert property (@(posedge clk) disable iff (!reset_n) in_fire |-> busy_q[in_slot]);
  a_rsp_lanes:     assert property (@(posedge clk) disable iff (!reset_n)
                                    in_apply |-> ((in_rsp_mask & ~exp_mask_q[in_slot]) == '0));
  a_rsp_dup:       assert property (@(posedge clk) disable iff (!reset_n)
                                    in_apply |-> ((eff & got_mask_q[in_slot]) == '0));
  a_rsp_tag:       assert property (@(posedge clk) disable iff (!reset_n)
                                    in_apply |-> (in_rsp_tag == tag_q[in_slot]));
endmodule

// File: tb/tb_vx_mem_rsp_gather.sv
// Directed bench for vx_mem_rsp_gather: gathers, ordering, backpressure, slot stall and reset.
module tb_vx_mem_rsp_gather;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_rw;
  logic [3:0]   req_mask;
  logic [7:0]   req_tag;
  logic         req_stall;
  logic         in_rsp_valid;
  logic [3:0]   in_rsp_mask;
  logic [127:0] in_rsp_data;
  logic [7:0]   in_rsp_tag;
  logic         in_rsp_ready;
  logic         out_rsp_valid;
  logic [3:0]   out_rsp_mask;
  logic [127:0] out_rsp_data;
  logic [7:0]   out_rsp_tag;
  logic         out_rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  vx_mem_rsp_gather dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_mask(req_mask), .req_tag(req_tag), .req_stall(req_stall),
    .in_rsp_valid(in_rsp_valid), .in_rsp_mask(in_rsp_mask), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_mask(out_rsp_mask), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic rw, input logic [3:0] mask, input logic [7:0] tag);
    req_valid = 1'b1; req_rw = rw; req_mask = mask; req_tag = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [3:0] mask, input logic [127:0] data, input logic [7:0] tag);
    in_rsp_valid = 1'b1; in_rsp_mask = mask; in_rsp_data = data; in_rsp_tag = tag;
    tick();
    in_rsp_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_ready = 1'b1; req_rw = 1'b0;
    req_mask = '0; req_tag = '0; in_rsp_valid = 1'b0; in_rsp_mask = '0;
    in_rsp_data = '0; in_rsp_tag = '0; out_rsp_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("reset_valid", out_rsp_valid, 0);
    check("reset_tag", out_rsp_tag, 0);
    check("reset_in_ready", in_rsp_ready, 1);
    check("reset_stall", req_stall, 0);

    // 1: two partials merged into one full response
    send_req(1'b0, 4'b1111, 8'h05);
    check("t1_stall_busy", req_stall, 1);
    send_rsp(4'b0011, {32'h0, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001}, 8'h05);
    check("t1_no_early_out", out_rsp_valid, 0);
    send_rsp(4'b1100, {32'hDDDD_0004, 32'hCCCC_0003, 32'h0, 32'h0}, 8'h05);
    check("t1_valid", out_rsp_valid, 1);
    check("t1_mask", out_rsp_mask, 4'b1111);
    check("t1_data", out_rsp_data, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    check("t1_tag", out_rsp_tag, 8'h05);
    tick();
    check("t1_single_out", out_rsp_valid, 0);

    // 2: single partial completes a sparse request; slot freed next cycle
    send_req(1'b0, 4'b0101, 8'h02);
    send_rsp(4'b0101, {32'h0, 32'h2222_0002, 32'h0, 32'h2222_0000}, 8'h02);
    check("t2_valid", out_rsp_valid, 1);
    check("t2_mask", out_rsp_mask, 4'b0101);
    check("t2_tag", out_rsp_tag, 8'h02);
    check("t2_lane0", out_rsp_data[31:0], 32'h2222_0000);
    check("t2_lane2", out_rsp_data[95:64], 32'h2222_0002);
    req_tag = 8'h02; #1;
    check("t2_stall_free", req_stall, 0);
    tick();

    // 3: out-of-order completion across two slots
    send_req(1'b0, 4'b1111, 8'h01);
    send_req(1'b0, 4'b0011, 8'h02);
    send_rsp(4'b0011, {64'h0, 32'h3333_0021, 32'h3333_0020}, 8'h02);
    check("t3_first_tag", out_rsp_tag, 8'h02);
    check("t3_first_data", out_rsp_data[63:0], {32'h3333_0021, 32'h3333_0020});
    send_rsp(4'b0011, {64'h0, 32'h3333_0011, 32'h3333_0010}, 8'h01);
    check("t3_gap", out_rsp_valid, 0);
    send_rsp(4'b1100, {32'h3333_0013, 32'h3333_0012, 64'h0}, 8'h01);
    check("t3_second_valid", out_rsp_valid, 1);
    check("t3_second_tag", out_rsp_tag, 8'h01);
    check("t3_second_data", out_rsp_data,
          {32'h3333_0013, 32'h3333_0012, 32'h3333_0011, 32'h3333_0010});
    tick();

    // 4: backpressure holds output, then back-to-back drain and reload
    send_req(1'b0, 4'b0001, 8'h04);
    send_req(1'b0, 4'b0001, 8'h06);
    out_rsp_ready = 1'b0;
    send_rsp(4'b0001, {96'h0, 32'h4444_0004}, 8'h04);
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0001; in_rsp_data = {96'h0, 32'h4444_0006}; in_rsp_tag = 8'h06;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_in_ready_low", in_rsp_ready, 0);
      check("t4_hold_valid", out_rsp_valid, 1);
      check("t4_hold_tag", out_rsp_tag, 8'h04);
      check("t4_hold_data", out_rsp_data, {96'h0, 32'h4444_0004});
      tick();
    end
    out_rsp_ready = 1'b1; #1;
    check("t4_in_ready_high", in_rsp_ready, 1);
    check("t4_drain_tag", out_rsp_tag, 8'h04);
    tick();
    in_rsp_valid = 1'b0;
    check("t4_b2b_valid", out_rsp_valid, 1);
    check("t4_b2b_tag", out_rsp_tag, 8'h06);
    check("t4_b2b_data", out_rsp_data, {96'h0, 32'h4444_0006});
    tick();
    check("t4_drained", out_rsp_valid, 0);

    // 5: aliasing tag stalls until the slot frees; writes record nothing
    send_req(1'b0, 4'b1111, 8'h03);
    req_tag = 8'h0B; #1;
    check("t5_alias_stall", req_stall, 1);
    tick();
    check("t5_alias_still", req_stall, 1);
    send_rsp(4'b1111, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, 8'h03);
    check("t5_done_tag", out_rsp_tag, 8'h03);
    req_tag = 8'h0B; #1;
    check("t5_stall_drop", req_stall, 0);
    send_req(1'b1, 4'b1111, 8'h0B);
    req_tag = 8'h0B; #1;
    check("t5_write_ignored", req_stall, 0);

    // 6: async reset mid-gather, then a clean gather on the same tag
    send_req(1'b0, 4'b1111, 8'h05);
    send_req(1'b0, 4'b0001, 8'h07);
    send_rsp(4'b0011, {64'h0, 32'h6666_0001, 32'h6666_0000}, 8'h05);
    out_rsp_ready = 1'b0;
    send_rsp(4'b0001, {96'h0, 32'h7777_0000}, 8'h07);
    check("t6_pre_valid", out_rsp_valid, 1);
    #2 reset_n = 1'b0; #1;
    check("t6_rst_valid", out_rsp_valid, 0);
    check("t6_rst_mask", out_rsp_mask, 0);
    check("t6_rst_data", out_rsp_data, 0);
    check("t6_rst_tag", out_rsp_tag, 0);
    req_tag = 8'h05; #1;
    check("t6_rst_busy", req_stall, 0);
    tick();
    reset_n = 1'b1; out_rsp_ready = 1'b1;
    tick();
    send_req(1'b0, 4'b1111, 8'h05);
    send_rsp(4'b1100, {32'h8888_0003, 32'h8888_0002, 64'h0}, 8'h05);
    check("t6_no_stale_complete", out_rsp_valid, 0);
    send_rsp(4'b0011, {64'h0, 32'h8888_0001, 32'h8888_0000}, 8'h05);
    check("t6_fresh_valid", out_rsp_valid, 1);
    check("t6_fresh_tag", out_rsp_tag, 8'h05);
    check("t6_fresh_data", out_rsp_data,
          {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
